// File: rtl/ym_bus_pkg.sv
// ---------------------------------------------------------------------------
// ym_bus_pkg : shared FSM state and command types for the YM bus writer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ym_bus_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    A_WAIT   = 4'd4,
    D_SETUP  = 4'd5,
    D_STROBE = 4'd6,
    D_HOLD   = 4'd7,
    D_WAIT   = 4'd8
  } state_t;

  typedef struct packed {
    logic [4:0] chip;
    logic       port;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ym_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ym_cmd_fifo : single-clock command FIFO with full/empty flags
// Rev 1.0 ; DEPTH must be a power of two, >= 2
// ---------------------------------------------------------------------------
`default_nettype none

module ym_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/ym_bus_writer.sv
// ---------------------------------------------------------------------------
// ym_bus_writer : queued, timed address/data write engine for YM sound chips
// Rev 1.0 ; optional address-phase cache enabled by YM_ADDR_CACHE_EN
// ---------------------------------------------------------------------------
`default_nettype none

module ym_bus_writer
  import ym_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int HOLD_CYC   = 2,
  parameter int ADDR_WAIT  = 32,
  parameter int DATA_WAIT  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_chip,
  input  logic       cmd_port,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic [4:0] cs,
  output logic [1:0] addr,
  output logic [7:0] din,
  output logic       wr_n,
  output logic       busy,
  output logic       overflow
);

  localparam int MAX_DUR = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC),
                                           max_int(HOLD_CYC, ADDR_WAIT)), DATA_WAIT);
  localparam int CNT_W   = $clog2(MAX_DUR + 1);

  // Every timed state lasts at least one cycle, so N-1 never underflows.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] AWAIT_LD = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DWAIT_LD = CNT_W'(DATA_WAIT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  cmd_t             in_cmd;
  cmd_t             head;
  cmd_t             cur;
  cmd_t             active;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             ready_en;
  logic             cache_hit;

  logic [4:0]       cs_nx;
  logic [1:0]       addr_nx;
  logic [7:0]       din_nx;
  logic             wr_n_nx;

  assign in_cmd    = '{chip: cmd_chip, port: cmd_port, reg_addr: cmd_reg, data: cmd_data};
  assign cmd_ready = ready_en && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !fifo_empty || (state != IDLE);

  ym_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef YM_ADDR_CACHE_EN
  logic        cache_valid;
  logic [13:0] cache_key;

  assign cache_hit = cache_valid && (cache_key == {head.chip, head.port, head.reg_addr});

  // A dropped chip-0 command breaks the chain of known address latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
    end else if (pop) begin
      if (head.chip == 5'd0) begin
        cache_valid <= 1'b0;
      end else begin
        cache_valid <= 1'b1;
        cache_key   <= {head.chip, head.port, head.reg_addr};
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // State register and shared down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.chip != 5'd0) state_nx = cache_hit ? D_SETUP : A_SETUP;
        end
      end
      A_SETUP:  if (cnt == '0) state_nx = A_STROBE;
      A_STROBE: if (cnt == '0) state_nx = A_HOLD;
      A_HOLD:   if (cnt == '0) state_nx = A_WAIT;
      A_WAIT:   if (cnt == '0) state_nx = D_SETUP;
      D_SETUP:  if (cnt == '0) state_nx = D_STROBE;
      D_STROBE: if (cnt == '0) state_nx = D_HOLD;
      D_HOLD:   if (cnt == '0) state_nx = D_WAIT;
      D_WAIT:   if (cnt == '0) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state) begin
      case (state_nx)
        A_SETUP,  D_SETUP:  cnt_nx = SETUP_LD;
        A_STROBE, D_STROBE: cnt_nx = PULSE_LD;
        A_HOLD,   D_HOLD:   cnt_nx = HOLD_LD;
        A_WAIT:             cnt_nx = AWAIT_LD;
        D_WAIT:             cnt_nx = DWAIT_LD;
        default:            cnt_nx = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nx = cnt - 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so the bus
  // changes on the same edge as the state and wr_n cannot glitch.
  assign active = pop ? head : cur;

  always_comb begin
    cs_nx   = '0;
    addr_nx = '0;
    din_nx  = '0;
    wr_n_nx = !((state_nx == A_STROBE) || (state_nx == D_STROBE));
    case (state_nx)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_nx   = active.chip;
        addr_nx = {active.port, 1'b0};
        din_nx  = active.reg_addr;
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_nx   = active.chip;
        addr_nx = {active.port, 1'b1};
        din_nx  = active.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs       <= '0;
      addr     <= '0;
      din      <= '0;
      wr_n     <= 1'b1;
      cur      <= '0;
      ready_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cs       <= cs_nx;
      addr     <= addr_nx;
      din      <= din_nx;
      wr_n     <= wr_n_nx;
      ready_en <= 1'b1;
      if (pop) cur <= head;
      if (cmd_valid && !cmd_ready) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ym_bus_writer.sv
// ---------------------------------------------------------------------------
// tb_ym_bus_writer : directed self-checking bench for ym_bus_writer
// Rev 1.0 ; expectations follow YM_ADDR_CACHE_EN when it is defined
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ym_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_chip = '0;
  logic       cmd_port = 1'b0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic [4:0] cs;
  logic [1:0] addr;
  logic [7:0] din;
  logic       wr_n;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ym_bus_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chip  (cmd_chip),
    .cmd_port  (cmd_port),
    .cmd_reg   (cmd_reg),
    .cmd_data  (cmd_data),
    .cs        (cs),
    .addr      (addr),
    .din       (din),
    .wr_n      (wr_n),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus trace {cs, addr, din, wr_n} per cycle, plus a log of every wr_n pulse.
  logic [15:0] tr [0:8191];

  typedef struct {
    int         start;
    int         len;
    logic [4:0] cs;
    logic [1:0] addr;
    logic [7:0] din;
    bit         stable;
  } strobe_t;

  strobe_t slog[$];
  strobe_t cur;
  logic    prev_wr = 1'b1;

  always @(negedge clk) begin
    if (cyc < 8192) tr[cyc] <= {cs, addr, din, wr_n};
    if (prev_wr === 1'b1 && wr_n === 1'b0) begin
      cur.start  <= cyc;
      cur.cs     <= cs;
      cur.addr   <= addr;
      cur.din    <= din;
      cur.stable <= 1'b1;
    end else if (prev_wr === 1'b0 && wr_n === 1'b0) begin
      if ({cs, addr, din} !== {cur.cs, cur.addr, cur.din}) cur.stable <= 1'b0;
    end else if (prev_wr === 1'b0 && wr_n === 1'b1) begin
      slog.push_back('{cur.start, cyc - cur.start, cur.cs, cur.addr, cur.din, cur.stable});
    end
    prev_wr <= wr_n;
  end

  // Expected bus for one command, offset measured from its first setup cycle
  // (default timing 2/4/2, address wait 32, data wait 200).
  function automatic logic [15:0] exp_bus(input int off, input logic [4:0] ch,
                                          input logic p, input logic [7:0] rg,
                                          input logic [7:0] dt, input bit with_addr);
    int o;
    o = with_addr ? off : off + 40;
    if (o < 2)       return {ch, p, 1'b0, rg, 1'b1};
    else if (o < 6)  return {ch, p, 1'b0, rg, 1'b0};
    else if (o < 8)  return {ch, p, 1'b0, rg, 1'b1};
    else if (o < 40) return 16'h0001;
    else if (o < 42) return {ch, p, 1'b1, dt, 1'b1};
    else if (o < 46) return {ch, p, 1'b1, dt, 1'b0};
    else if (o < 48) return {ch, p, 1'b1, dt, 1'b1};
    else             return 16'h0001;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step;
      n++;
    end
  endtask

  task automatic push_cmd(input logic [4:0] ch, input logic p, input logic [7:0] rg,
                          input logic [7:0] dt, output int acc);
    cmd_valid = 1'b1;
    cmd_chip  = ch;
    cmd_port  = p;
    cmd_reg   = rg;
    cmd_data  = dt;
    acc       = cyc;
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++;
    if ({cs, addr, din, wr_n} !== 16'h0001) begin
      errors++;
      $display("FAIL reset_bus: got %h required 0001", {cs, addr, din, wr_n});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0", cmd_ready);
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b overflow=%b required 0 0", busy, overflow);
    end
    rst = 1'b0;
    step;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_single_write;
    int c0, n0, nbad, first;
    n0 = slog.size();
    push_cmd(5'd3, 1'b0, 8'h28, 8'hF0, c0);
    checks++;
    if (busy !== 1'b1 || cs !== 5'd0) begin
      errors++;
      $display("FAIL pop_cycle: busy=%b cs=%0d required 1 0", busy, cs);
    end
    step;
    checks++;
    if ({cs, addr, din, wr_n} !== {5'd3, 2'b00, 8'h28, 1'b1}) begin
      errors++;
      $display("FAIL issue_latency: got %h required %h", {cs, addr, din, wr_n},
               {5'd3, 2'b00, 8'h28, 1'b1});
    end
    wait_idle(400);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b required 0", busy);
    end
    repeat (15) step;
    nbad = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (tr[c0 + 2 + k] !== exp_bus(k, 5'd3, 1'b0, 8'h28, 8'hF0, 1'b1)) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL single_timeline: %0d bad cycles, first at offset %0d got %h required %h",
               nbad, first, tr[c0 + 2 + first],
               exp_bus(first, 5'd3, 1'b0, 8'h28, 8'hF0, 1'b1));
    end
    checks++;
    if (slog.size() != n0 + 2) begin
      errors++;
      $display("FAIL single_strobes: got %0d strobes required 2", slog.size() - n0);
    end else if (slog[n0].len != 4 || slog[n0 + 1].len != 4 ||
                 !slog[n0].stable || !slog[n0 + 1].stable) begin
      errors++;
      $display("FAIL single_strobes: lengths %0d %0d required 4 4 with stable bus",
               slog[n0].len, slog[n0 + 1].len);
    end
  endtask

  task automatic test_back_to_back;
    int c0, n0, dummy;
    wait_idle(400);
    n0 = slog.size();
    push_cmd(5'd1, 1'b0, 8'h10, 8'h20, c0);
    step;
    step;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b required 1", i, cmd_ready);
      end
      push_cmd(5'(i + 1), 1'b0, 8'(16 + i), 8'(32 + i), dummy);
    end
    checks++;
    if (cmd_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: ready=%b overflow=%b required 0 0", cmd_ready, overflow);
    end
    cmd_valid = 1'b1;
    cmd_chip  = 5'd6;
    cmd_port  = 1'b0;
    cmd_reg   = 8'h15;
    cmd_data  = 8'h25;
    repeat (3) step;
    checks++;
    if (overflow !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow: overflow=%b ready=%b required 1 0", overflow, cmd_ready);
    end
    cmd_valid = 1'b0;
    wait_idle(1500);
    step;
    checks++;
    if (slog.size() != n0 + 10) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes required 10", slog.size() - n0);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (slog.size() < n0 + 2 * k + 2) begin
        errors++;
        $display("FAIL b2b_cmd_%0d: strobe missing", k);
      end else if (slog[n0 + 2 * k].cs !== 5'(k + 1) || slog[n0 + 2 * k].din !== 8'(16 + k) ||
                   slog[n0 + 2 * k + 1].din !== 8'(32 + k) ||
                   slog[n0 + 2 * k].start != c0 + 4 + 249 * k) begin
        errors++;
        $display("FAIL b2b_cmd_%0d: cs=%0d reg=%h data=%h start=%0d required %0d %h %h %0d",
                 k, slog[n0 + 2 * k].cs, slog[n0 + 2 * k].din, slog[n0 + 2 * k + 1].din,
                 slog[n0 + 2 * k].start, k + 1, 16 + k, 32 + k, c0 + 4 + 249 * k);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_chip0_drop;
    int ca, n0, dummy, nbad, first;
    wait_idle(400);
    n0 = slog.size();
    push_cmd(5'd2, 1'b0, 8'h30, 8'h40, ca);
    push_cmd(5'd0, 1'b1, 8'h99, 8'h99, dummy);
    push_cmd(5'd2, 1'b0, 8'h30, 8'h41, dummy);
    wait_idle(800);
    repeat (5) step;
    checks++;
    if (tr[ca + 250] !== 16'h0001 || tr[ca + 251] !== 16'h0001) begin
      errors++;
      $display("FAIL chip0_gap: got %h %h required 0001 0001", tr[ca + 250], tr[ca + 251]);
    end
    nbad = 0;
    first = -1;
    for (int k = 0; k < 60; k++) begin
      if (tr[ca + 252 + k] !== exp_bus(k, 5'd2, 1'b0, 8'h30, 8'h41, 1'b1)) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL chip0_next_cmd: %0d bad cycles, first at offset %0d got %h required %h",
               nbad, first, tr[ca + 252 + first],
               exp_bus(first, 5'd2, 1'b0, 8'h30, 8'h41, 1'b1));
    end
    checks++;
    if (slog.size() != n0 + 4) begin
      errors++;
      $display("FAIL chip0_strobes: got %0d strobes required 4", slog.size() - n0);
    end
  endtask

  task automatic test_reset_mid_strobe;
    int c0, n0, dummy;
    wait_idle(400);
    n0 = slog.size();
    push_cmd(5'd7, 1'b1, 8'h11, 8'h22, c0);
    push_cmd(5'd8, 1'b0, 8'h33, 8'h44, dummy);
    while (cyc < c0 + 45) step;
    checks++;
    if (wr_n !== 1'b0 || addr !== 2'b11) begin
      errors++;
      $display("FAIL mid_in_dstrobe: wr_n=%b addr=%b required 0 11", wr_n, addr);
    end
    rst = 1'b1;
    step;
    checks++;
    if (wr_n !== 1'b1 || cs !== 5'd0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: wr_n=%b cs=%0d busy=%b ready=%b ovf=%b required 1 0 0 0 0",
               wr_n, cs, busy, cmd_ready, overflow);
    end
    rst = 1'b0;
    step;
    repeat (5) step;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || cs !== 5'd0) begin
      errors++;
      $display("FAIL mid_flushed: busy=%b ready=%b cs=%0d required 0 1 0", busy, cmd_ready, cs);
    end
    checks++;
    if (slog.size() != n0 + 2) begin
      errors++;
      $display("FAIL mid_strobes: got %0d strobes required 2", slog.size() - n0);
    end else if (slog[n0 + 1].din !== 8'h22 || slog[n0 + 1].len != 2) begin
      errors++;
      $display("FAIL mid_cut_strobe: din=%h len=%0d required 22 2",
               slog[n0 + 1].din, slog[n0 + 1].len);
    end
  endtask

  task automatic test_addr_cache;
    int c0, n0, dummy, exp_n;
    logic [1:0] exp_addr;
    logic [7:0] exp_din;
    wait_idle(400);
    n0 = slog.size();
    push_cmd(5'd1, 1'b1, 8'hA4, 8'h11, c0);
    push_cmd(5'd1, 1'b1, 8'hA4, 8'h22, dummy);
    wait_idle(800);
    step;
`ifdef YM_ADDR_CACHE_EN
    exp_n    = 3;
    exp_addr = 2'b11;
    exp_din  = 8'h22;
`else
    exp_n    = 4;
    exp_addr = 2'b10;
    exp_din  = 8'hA4;
`endif
    checks++;
    if (slog.size() != n0 + exp_n) begin
      errors++;
      $display("FAIL cache_count: got %0d strobes required %0d", slog.size() - n0, exp_n);
    end else if (slog[n0 + 2].addr !== exp_addr || slog[n0 + 2].din !== exp_din ||
                 slog[n0 + 2].cs !== 5'd1 || slog[n0 + 2].start != c0 + 253) begin
      errors++;
      $display("FAIL cache_second: addr=%b din=%h cs=%0d start=%0d required %b %h 1 %0d",
               slog[n0 + 2].addr, slog[n0 + 2].din, slog[n0 + 2].cs, slog[n0 + 2].start,
               exp_addr, exp_din, c0 + 253);
    end
  endtask

  task automatic test_chip31;
    int c0, n0, nbad, first;
    wait_idle(400);
    n0 = slog.size();
    push_cmd(5'd31, 1'b1, 8'h55, 8'hAA, c0);
    wait_idle(400);
    repeat (15) step;
    nbad = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (tr[c0 + 2 + k] !== exp_bus(k, 5'd31, 1'b1, 8'h55, 8'hAA, 1'b1)) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL chip31_timeline: %0d bad cycles, first at offset %0d got %h required %h",
               nbad, first, tr[c0 + 2 + first],
               exp_bus(first, 5'd31, 1'b1, 8'h55, 8'hAA, 1'b1));
    end
    checks++;
    if (slog.size() != n0 + 2) begin
      errors++;
      $display("FAIL chip31_strobes: got %0d strobes required 2", slog.size() - n0);
    end else if (slog[n0].addr !== 2'b10 || slog[n0 + 1].addr !== 2'b11 ||
                 slog[n0].cs !== 5'd31 || slog[n0 + 1].cs !== 5'd31) begin
      errors++;
      $display("FAIL chip31_addr: addr %b %b cs %0d %0d required 10 11 31 31",
               slog[n0].addr, slog[n0 + 1].addr, slog[n0].cs, slog[n0 + 1].cs);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_back_to_back;
    test_chip0_drop;
    test_reset_mid_strobe;
    test_addr_cache;
    test_chip31;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
